// File: rtl/dip_switch_controller_if.sv
// Bus interface for dip_switch_controller.
// Signals:
//   addr   [3:0]  byte offset within the device window (only [3:2] decoded)
//   we            write strobe, one cycle per write
//   wdata  [31:0] write data
//   rdata  [31:0] read data, combinational from addr
// Modports: master (bus bridge side), slave (controller side).
interface dip_switch_controller_if;
  logic [3:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/dip_switch_controller.sv
// Debounce-and-event controller for eight 8-bit active-low DIP switch banks.
// Each bank is inverted, passed through a 2-flop synchronizer and debounced on
// a prescaled sample tick. Stable values are readable as DATA_LO/DATA_HI;
// per-bank change events go to a W1C STATUS register and raise irq.
// Optional feature macro: DIP_SWITCH_IRQ_EN (STATUS/CTRL/irq). Without it the
// event registers are absent, STATUS/CTRL read 0 and irq is tied low.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   dip_switch0..7      raw switch pins, low = switch on
//   bus                 register bus (slave modport)
//   irq                 level interrupt request (ien & |changed)
// Parameters:
//   SAMPLE_DIV  clock cycles per sample tick (>=1)
//   STABLE_CNT  equal samples needed to accept a new value (1..15)
module dip_switch_controller #(
  parameter int unsigned SAMPLE_DIV = 25000,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               dip_switch0,
  input  logic [7:0]               dip_switch1,
  input  logic [7:0]               dip_switch2,
  input  logic [7:0]               dip_switch3,
  input  logic [7:0]               dip_switch4,
  input  logic [7:0]               dip_switch5,
  input  logic [7:0]               dip_switch6,
  input  logic [7:0]               dip_switch7,
  dip_switch_controller_if.slave   bus,
  output logic                     irq
);

  localparam int unsigned PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SAMPLE_DIV - 1);
  localparam logic [3:0] SCNT = 4'(STABLE_CNT);

  logic [7:0] raw    [8];
  logic [7:0] sync1  [8];
  logic [7:0] sync2  [8];
  logic [7:0] cand   [8];
  logic [7:0] cand_n [8];
  logic [3:0] cnt    [8];
  logic [3:0] cnt_n  [8];
  logic [7:0] stable [8];
  logic [7:0] upd;

  logic [PW-1:0] pcnt;
  logic          tick;

  assign raw[0] = dip_switch0;
  assign raw[1] = dip_switch1;
  assign raw[2] = dip_switch2;
  assign raw[3] = dip_switch3;
  assign raw[4] = dip_switch4;
  assign raw[5] = dip_switch5;
  assign raw[6] = dip_switch6;
  assign raw[7] = dip_switch7;

  // Prescaler: 0..SAMPLE_DIV-1, tick on the terminal count.
  assign tick = (pcnt == PMAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Next-state of the debounce counters; upd[i] marks the edge where the
  // post-update count reaches STABLE_CNT with a candidate differing from stable.
  always_comb begin
    upd = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand_n[i] = cand[i];
      cnt_n[i]  = cnt[i];
      if (tick) begin
        if (sync2[i] != cand[i]) begin
          cand_n[i] = sync2[i];
          cnt_n[i]  = 4'd1;
        end else if (cnt[i] < SCNT) begin
          cnt_n[i] = cnt[i] + 4'd1;
        end
        upd[i] = (cnt_n[i] == SCNT) && (cand_n[i] != stable[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 8; i++) begin
        sync1[i]  <= '0;
        sync2[i]  <= '0;
        cand[i]   <= '0;
        cnt[i]    <= '0;
        stable[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        sync1[i] <= ~raw[i];
        sync2[i] <= sync1[i];
        cand[i]  <= cand_n[i];
        cnt[i]   <= cnt_n[i];
        if (upd[i]) begin
          stable[i] <= cand_n[i];
        end
      end
    end
  end

`ifdef DIP_SWITCH_IRQ_EN
  logic [7:0] changed;
  logic [7:0] mask;
  logic       ien;
  logic       sel_status;
  logic       sel_ctrl;
  logic [7:0] clr;
  logic       unused_bits;

  assign sel_status  = bus.we && (bus.addr[3:2] == 2'd2);
  assign sel_ctrl    = bus.we && (bus.addr[3:2] == 2'd3);
  assign clr         = sel_status ? bus.wdata[7:0] : '0;
  assign unused_bits = ^{bus.wdata[31:16], bus.addr[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed <= '0;
      mask    <= '0;
      ien     <= 1'b0;
    end else begin
      if (sel_ctrl) begin
        ien  <= bus.wdata[0];
        mask <= bus.wdata[15:8];
      end
      // Set is ORed in after the clear so a same-cycle event wins.
      changed <= (changed & ~clr) | (upd & mask);
    end
  end

  assign irq = ien & (|changed);

  always_comb begin
    bus.rdata = '0;
    case (bus.addr[3:2])
      2'd0:    bus.rdata = {stable[3], stable[2], stable[1], stable[0]};
      2'd1:    bus.rdata = {stable[7], stable[6], stable[5], stable[4]};
      2'd2:    bus.rdata = {24'd0, changed};
      default: bus.rdata = {16'd0, mask, 7'd0, ien};
    endcase
  end
`else
  logic unused_bits;

  assign unused_bits = ^{bus.we, bus.wdata, bus.addr[1:0]};
  assign irq         = 1'b0;

  always_comb begin
    bus.rdata = '0;
    case (bus.addr[3:2])
      2'd0:    bus.rdata = {stable[3], stable[2], stable[1], stable[0]};
      2'd1:    bus.rdata = {stable[7], stable[6], stable[5], stable[4]};
      default: bus.rdata = '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_dip_switch_controller.sv
// Self-checking bench for dip_switch_controller (SAMPLE_DIV=4, STABLE_CNT=3).
// Expectations for STATUS/CTRL/irq follow DIP_SWITCH_IRQ_EN.
module tb_dip_switch_controller;

`ifdef DIP_SWITCH_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam logic [3:0] A_LO = 4'h0;
  localparam logic [3:0] A_HI = 4'h4;
  localparam logic [3:0] A_ST = 4'h8;
  localparam logic [3:0] A_CT = 4'hC;

  typedef struct packed {
    logic [63:0] pins;   // bank i raw pins at [8*i +: 8]
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic [7:0] sw [8];
  logic       irq;

  int checks;
  int failures;
  logic [31:0] sbq [$];

  dip_switch_controller_if bus_if ();

  dip_switch_controller #(.SAMPLE_DIV(4), .STABLE_CNT(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dip_switch0 (sw[0]),
    .dip_switch1 (sw[1]),
    .dip_switch2 (sw[2]),
    .dip_switch3 (sw[3]),
    .dip_switch4 (sw[4]),
    .dip_switch5 (sw[5]),
    .dip_switch6 (sw[6]),
    .dip_switch7 (sw[7]),
    .bus         (bus_if),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus_if.addr = a;
    #1;
    d = bus_if.rdata;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus_if.addr  = a;
    bus_if.wdata = d;
    bus_if.we    = 1'b1;
    @(posedge clk);
    #1;
    bus_if.we = 1'b0;
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int b = 0; b < 8; b++) sw[b] = v;
  endtask

  // Leaves the bench at posedge+1 with reset_n just released; the next
  // rising edge is the first one with reset_n high.
  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t        vecs [4];
    logic [31:0] d;
    int          bad;
    int          first_k;

    vecs[0] = '{pins: 64'hFFFFFFFFFFFFFF00, lo: 32'h000000FF, hi: 32'h00000000};
    vecs[1] = '{pins: 64'h7FBFDFEFF7FBFDFE, lo: 32'h08040201, hi: 32'h80402010};
    vecs[2] = '{pins: 64'h78563412F00F3CA5, lo: 32'h0FF0C35A, hi: 32'h87A9CBED};
    vecs[3] = '{pins: 64'h0000000000000000, lo: 32'hFFFFFFFF, hi: 32'hFFFFFFFF};

    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    bus_if.addr = '0;
    bus_if.we = 1'b0;
    bus_if.wdata = '0;
    set_all(8'hFF);

    // Reset state
    do_reset();
    rd(A_LO, d); check("reset_data_lo", d, 32'h0);
    rd(A_HI, d); check("reset_data_hi", d, 32'h0);
    rd(A_ST, d); check("reset_status", d, 32'h0);
    rd(A_CT, d); check("reset_ctrl", d, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    step(30);
    rd(A_LO, d); check("idle_data_lo", d, 32'h0);

    // First-tick timing and set/clear collision: pin pressed through reset,
    // ticks at edges 4, 8, 12 after release, stable updates on edge 12.
    sw[0] = 8'hFE;
    do_reset();
    wr(A_CT, 32'h0000_0101);        // edge 1
    repeat (10) @(posedge clk);     // edge 11
    #1;
    rd(A_LO, d); check("tick_edge11_data_lo", d, 32'h0);
    rd(A_ST, d); check("tick_edge11_status", d, 32'h0);
    wr(A_ST, 32'h1);                // W1C lands on edge 12
    rd(A_LO, d); check("tick_edge12_data_lo", d, 32'h1);
    rd(A_ST, d); check("collision_status", d, IRQ_EN ? 32'h1 : 32'h0);
    check("collision_irq", {31'd0, irq}, {31'd0, IRQ_EN});
    wr(A_ST, 32'h1);
    rd(A_ST, d); check("w1c_status", d, 32'h0);
    check("w1c_irq", {31'd0, irq}, 32'h0);

    // Clean press
    set_all(8'hFF);
    do_reset();
    step(5);
    sw[0] = 8'hFE;
    bad = 0;
    first_k = 99;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      rd(A_LO, d);
      if (d !== 32'h0 && d !== 32'h1) bad++;
      if (d === 32'h1 && first_k == 99) first_k = k;
    end
    check("press_no_intermediate", bad, 32'd0);
    check("press_latency_le14", {31'd0, (first_k <= 14)}, 32'h1);
    check("press_final", d, 32'h1);

    // Glitch rejection: 8 cycles of low covers exactly two ticks
    set_all(8'hFF);
    do_reset();
    wr(A_CT, 32'h0000_2001);
    sw[5] = 8'h00;
    step(8);
    sw[5] = 8'hFF;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      rd(A_HI, d);
      if (d !== 32'h0) bad++;
      rd(A_ST, d);
      if (d[5] !== 1'b0) bad++;
    end
    check("glitch_rejected", bad, 32'd0);

    // Interrupt flow
    do_reset();
    wr(A_CT, 32'h0000_FF01);
    rd(A_CT, d); check("ctrl_readback", d, IRQ_EN ? 32'h0000FF01 : 32'h0);
    sw[7] = 8'h7F;
    step(20);
    rd(A_HI, d); check("irqflow_data_hi", d, 32'h80000000);
    rd(A_ST, d); check("irqflow_status", d, IRQ_EN ? 32'h80 : 32'h0);
    check("irqflow_irq", {31'd0, irq}, {31'd0, IRQ_EN});
    wr(A_ST, 32'h80);
    rd(A_ST, d); check("irqflow_cleared_status", d, 32'h0);
    check("irqflow_cleared_irq", {31'd0, irq}, 32'h0);

    // Masking: bank2 masked off
    set_all(8'hFF);
    do_reset();
    wr(A_CT, 32'h0000_FB01);
    sw[2] = 8'h0F;
    step(20);
    rd(A_LO, d); check("mask_data_lo", d, 32'h00F00000);
    rd(A_ST, d); check("mask_status", d, 32'h0);
    check("mask_irq", {31'd0, irq}, 32'h0);

    // Reset mid-debounce: clears DATA asynchronously, debounce restarts
    sw[1] = 8'h00;
    step(6);
    reset_n = 1'b0;
    rd(A_LO, d); check("midreset_async_clear", d, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    rd(A_LO, d); check("midreset_edge11", d, 32'h0);
    step(1);
    rd(A_LO, d); check("midreset_edge12", d, 32'h00F0FF00);

    // Table-driven bank patterns through the scoreboard
    set_all(8'hFF);
    do_reset();
    for (int v = 0; v < 4; v++) begin
      for (int b = 0; b < 8; b++) sw[b] = vecs[v].pins[8*b +: 8];
      sbq.push_back(vecs[v].lo);
      sbq.push_back(vecs[v].hi);
      step(20);
      rd(A_LO, d); check($sformatf("vec%0d_data_lo", v), d, sbq.pop_front());
      rd(4'h7, d); check($sformatf("vec%0d_data_hi", v), d, sbq.pop_front());
    end
    check("scoreboard_empty", sbq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
